// File: rtl/sub_bytes_pkg.sv
// Shared types and constants for the byte-serial AES SubBytes sequencer.
// Holds the FSM state encoding, state-word geometry and index width.
package sub_bytes_pkg;

    localparam int NBYTES = 16;
    localparam int BYTE_W = 8;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Word-level handshake bundle for sub_bytes_seq.
// master: producer/consumer side; slave: the sequencer.
interface sub_bytes_seq_if;
    import sub_bytes_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [NBYTES*BYTE_W-1:0] in_state;
    logic                     out_valid;
    logic                     out_ready;
    logic [NBYTES*BYTE_W-1:0] out_state;
    logic                     out_error;
    logic [CNT_W-1:0]         err_cnt;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state,
        input  out_error, err_cnt
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state,
        output out_error, err_cnt
    );

endinterface

// File: rtl/sbox_checked.sv
// Combinational AES S-box (GF(2^8) inverse + affine) with parity check.
// Ports: sb_in byte in; sb_out substituted byte; sb_err parity mismatch.
module sbox_checked (
    input  logic [7:0] sb_in,
    output logic [7:0] sb_out,
    output logic       sb_err
);
    import sub_bytes_pkg::*;

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(
        input logic [7:0] a,
        input int         n
    );
        return (a << n) | (a >> (8 - n));
    endfunction

    logic [7:0] inv;
    logic       par_pred;

    // Each inverse bit feeds five output bits and 8'h63 has even
    // parity, so the output parity must equal the inverse parity.
    always_comb begin
        inv = gf_inv(sb_in);
        sb_out = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
               ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        par_pred = ^inv;
        sb_err = (^sb_out) != par_pred;
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Byte-serial SubBytes sequencer sharing one external checked S-box.
// Ports: clk, rst (sync high), bus (word handshake), sb_in/sb_out/sb_err.
module sub_bytes_seq #(
    parameter int NBYTES      = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    sub_bytes_seq_if.slave  bus,
    output logic [7:0]      sb_in,
    input  logic [7:0]      sb_out,
    input  logic            sb_err
);
    import sub_bytes_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    state_t                   state;
    state_t                   state_nx;
    logic [NBYTES*BYTE_W-1:0] wbuf;
    logic [IDX_W-1:0]         idx;
    logic                     err_q;
    logic [CNT_W-1:0]         cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wbuf  <= '0;
            idx   <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        wbuf  <= bus.in_state;
                        idx   <= '0;
                        err_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    wbuf[{idx, 3'b000} +: BYTE_W] <= sb_out;
                    if (sb_err) begin
                        err_q <= 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The lookup byte comes from the working buffer only, so the
    // S-box never sees in_state combinationally.
    always_comb begin
        state_nx = state;
        sb_in    = '0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) state_nx = RUN;
            end
            RUN: begin
                sb_in = wbuf[{idx, 3'b000} +: BYTE_W];
                if (idx == LAST || (STOP_ON_ERR && sb_err))
                    state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_state = wbuf;
    assign bus.out_error = err_q;
    assign bus.err_cnt   = cnt_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Randomized self-checking bench for sub_bytes_seq (both abort modes).
// Reference: AES S-box table plus a byte-loop model of the word rules.
module tb_sub_bytes_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic         out_ready;

    logic [7:0] sb_in0, sb_out0, sb_in1, sb_out1;
    logic       sbe0, sbe1, sb_err0, sb_err1;

    bit mask [256];

    int n_chk;
    int n_pass;

    sub_bytes_seq_if bus0 ();
    sub_bytes_seq_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_state  = in_state;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_state  = in_state;
    assign bus1.out_ready = out_ready;

    sbox_checked u_sb0 (.sb_in(sb_in0), .sb_out(sb_out0), .sb_err(sbe0));
    sbox_checked u_sb1 (.sb_in(sb_in1), .sb_out(sb_out1), .sb_err(sbe1));

    always_comb begin
        sb_err0 = sbe0 | mask[sb_in0];
        sb_err1 = sbe1 | mask[sb_in1];
    end

    sub_bytes_seq #(.NBYTES(16), .STOP_ON_ERR(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .sb_in(sb_in0), .sb_out(sb_out0), .sb_err(sb_err0)
    );

    sub_bytes_seq #(.NBYTES(16), .STOP_ON_ERR(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .sb_in(sb_in1), .sb_out(sb_out1), .sb_err(sb_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    task automatic check(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Word rules: bytes in order 0..15, each replaced by SBOX[b];
    // a masked byte counts as an error and, if stop, ends the word.
    function automatic void model(
        input  logic [127:0] w,
        input  bit           stop,
        output logic [127:0] o,
        output logic         e,
        output logic [4:0]   c,
        output int           nl
    );
        logic [7:0] b;
        o = w; e = 1'b0; c = '0; nl = 16;
        for (int k = 0; k < 16; k++) begin
            b = w[8*k +: 8];
            o[8*k +: 8] = SBOX[b];
            if (mask[b]) begin
                e = 1'b1;
                c = c + 5'd1;
                if (stop) begin
                    nl = k + 1;
                    break;
                end
            end
        end
    endfunction

    task automatic clear_mask();
        foreach (mask[i]) mask[i] = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!(bus0.in_ready && bus1.in_ready) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/ready_to"}, 128'(n < 60), 128'(1));
    endtask

    // Sends one word with out_ready=1; latency counts edges from the
    // accepting edge to the first edge that samples out_valid high.
    task automatic run_word(
        input  logic [127:0] w,
        input  string        tag,
        output logic [127:0] o0,
        output logic [127:0] o1
    );
        logic [127:0] eo0, eo1;
        logic         ee0, ee1;
        logic [4:0]   ec0, ec1;
        int           nl0, nl1;
        bit           d0, d1;
        model(w, 1'b0, eo0, ee0, ec0, nl0);
        model(w, 1'b1, eo1, ee1, ec1, nl1);
        o0 = '0; o1 = '0;
        out_ready = 1'b1;
        wait_ready(tag);
        in_state = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        d0 = 1'b0; d1 = 1'b0;
        for (int n = 1; n <= 40 && !(d0 && d1); n++) begin
            if (!d0 && bus0.out_valid) begin
                d0 = 1'b1;
                o0 = bus0.out_state;
                check({tag, "/s0"}, bus0.out_state, eo0);
                check({tag, "/e0"}, 128'(bus0.out_error), 128'(ee0));
                check({tag, "/c0"}, 128'(bus0.err_cnt), 128'(ec0));
                check({tag, "/lat0"}, 128'(n), 128'(nl0 + 1));
            end
            if (!d1 && bus1.out_valid) begin
                d1 = 1'b1;
                o1 = bus1.out_state;
                check({tag, "/s1"}, bus1.out_state, eo1);
                check({tag, "/e1"}, 128'(bus1.out_error), 128'(ee1));
                check({tag, "/c1"}, 128'(bus1.err_cnt), 128'(ec1));
                check({tag, "/lat1"}, 128'(n), 128'(nl1 + 1));
            end
            @(posedge clk); #1;
        end
        check({tag, "/done"}, 128'({d0, d1}), 128'(2'b11));
    endtask

    logic [127:0] w, o0, o1;
    logic [127:0] eo;
    logic         ee;
    logic [4:0]   ec;
    int           nl;
    int           seen;

    initial begin
        n_chk = 0;
        n_pass = 0;
        clear_mask();
        rst = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst/in_ready", 128'(bus0.in_ready), 128'(1));
        check("rst/out_valid", 128'(bus0.out_valid), 128'(0));
        check("rst/out_state", bus0.out_state, 128'(0));
        check("rst/out_error", 128'(bus0.out_error), 128'(0));
        check("rst/err_cnt", 128'(bus0.err_cnt), 128'(0));
        check("rst/sb_in", 128'(sb_in0), 128'(0));
        check("rst/in_ready1", 128'(bus1.in_ready), 128'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        run_word(128'(0), "zero", o0, o1);
        check("zero/all63", o0, {16{8'h63}});

        w = 128'h0f0e0d0c0b0a09080706050403020100;
        run_word(w, "seq", o0, o1);
        check("seq/vec", o0, 128'h76abd7fe2b670130c56f6bf27b777c63);

        mask[8'h05] = 1'b1;
        run_word(w, "err5", o0, o1);
        clear_mask();

        mask[8'h03] = 1'b1;
        run_word(w, "stop3", o0, o1);
        check("stop3/vec", o1, 128'h0f0e0d0c0b0a0908070605047b777c63);
        clear_mask();

        for (int t = 0; t < 24; t++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            clear_mask();
            if (t % 2 == 1) mask[w[8*$urandom_range(15, 0) +: 8]] = 1'b1;
            if (t % 3 == 0) mask[$urandom_range(255, 0)] = 1'b1;
            run_word(w, "rnd", o0, o1);
        end
        clear_mask();

        w = {$urandom, $urandom, $urandom, $urandom};
        model(w, 1'b0, eo, ee, ec, nl);
        out_ready = 1'b0;
        wait_ready("stall");
        in_state = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!(bus0.out_valid && bus1.out_valid) && seen < 40) begin
            @(posedge clk); #1;
            seen++;
        end
        check("stall/valid_to", 128'(seen < 40), 128'(1));
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check("stall/state", bus0.out_state, eo);
            check("stall/err", 128'(bus0.out_error), 128'(ee));
            check("stall/valid", 128'(bus0.out_valid), 128'(1));
            check("stall/in_ready", 128'(bus0.in_ready), 128'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall/idle", 128'(bus0.in_ready), 128'(1));
        check("stall/no_valid", 128'(bus0.out_valid), 128'(0));

        w = {$urandom, $urandom, $urandom, $urandom};
        wait_ready("mrst");
        in_state = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        check("mrst/in_ready", 128'(bus0.in_ready), 128'(1));
        check("mrst/out_valid", 128'(bus0.out_valid), 128'(0));
        check("mrst/err_cnt", 128'(bus0.err_cnt), 128'(0));
        check("mrst/out_state", bus0.out_state, 128'(0));
        check("mrst/in_ready1", 128'(bus1.in_ready), 128'(1));
        rst = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (bus0.out_valid || bus1.out_valid) seen++;
        end
        check("mrst/no_out", 128'(seen), 128'(0));

        run_word(128'(0), "post", o0, o1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 Parameter: NBYTES, 16, number of bytes in one state word; the block SHALL support only 16.
REQ-002 Parameter: STOP_ON_ERR, 0, when 1 the block SHALL abort a word at the first byte whose check flags an error.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: in_valid  in  1  input word offered.
REQ-007 Port: in_ready  out  1  block can accept a word.
REQ-008 Port: in_state  in  128  AES state; byte k = bits [8k+7:8k].
REQ-009 Port: sb_in  out  8  byte presented to the shared checked S-box.
REQ-010 Port: sb_out  in  8  S-box result, combinational from sb_in.
REQ-011 Port: sb_err  in  1  S-box parity-check error, combinational from sb_in.
REQ-012 Port: out_valid  out  1  result word available.
REQ-013 Port: out_ready  in  1  consumer accepts the result.
REQ-014 Port: out_state  out  128  substituted state, same byte ordering as in_state.
REQ-015 Port: out_error  out  1  at least one byte of this word flagged sb_err.
REQ-016 Port: err_cnt  out  5  number of flagged bytes in this word (0..16).

Function
REQ-017 FSM states: IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: on in_valid=1, register in_state into the working buffer, clear idx, out_error and err_cnt, go to RUN.
REQ-019 RUN: sb_in SHALL equal working byte[idx], driven from registers with no combinational path from in_state.
REQ-020 RUN edge: write sb_out into byte[idx]; if sb_err, set out_error and increment err_cnt; increment idx (4-bit).
REQ-021 RUN exit: after the edge with idx=15, go to DONE; idx SHALL NOT wrap into a 17th lookup.
REQ-022 STOP_ON_ERR=1: on the RUN edge where sb_err=1, store that byte's substituted value, leave later bytes unsubstituted, and go to DONE.
REQ-023 Latency: out_valid SHALL rise exactly 17 cycles after the accepting edge when no abort occurs.
REQ-024 DONE: out_valid=1; out_state, out_error and err_cnt SHALL be held stable until out_valid&out_ready, then return to IDLE.
REQ-025 in_valid while the block is in RUN or DONE SHALL be ignored and SHALL NOT corrupt the buffer.
REQ-026 A completion handshake and a new acceptance SHALL NOT share a cycle; minimum word period is 18 cycles.
REQ-027 sb_in SHALL be 8'h00 outside RUN.

Reset
REQ-028 With rst=1 at an edge: state IDLE, in_ready=1, out_valid=0, out_state=0, out_error=0, err_cnt=0, idx=0.
REQ-029 Reset in mid-RUN or DONE SHALL discard the word with no out_valid pulse; rst overrides in_valid.

Structure
REQ-030 Package sub_bytes_pkg SHALL hold the FSM state enum, NBYTES and the byte-width constant.
REQ-031 The checked S-box lookup with its parity predictor SHALL remain a separate sub-module, sbox_checked, instantiated beside this block and wired to sb_in/sb_out/sb_err; the sequencer SHALL contain no lookup table.

Verification
REQ-032 in_state=0 -> after 17 cycles out_state = 16 bytes of 8'h63, out_error=0, err_cnt=0.
REQ-033 in_state bytes 0..15 = 00..0f -> out bytes 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76.
REQ-034 Force sb_err=1 at byte 5 only, STOP_ON_ERR=0 -> out_error=1, err_cnt=1, out_valid still at 17 cycles.
REQ-035 STOP_ON_ERR=1, sb_err at byte 3, input 00..0f -> out_valid after 4 RUN cycles; bytes 0..3 = 63 7c 77 7b; bytes 4..15 unchanged.
REQ-036 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid -> outputs stable, in_ready=0, no second word accepted.
REQ-037 Assert rst at idx=8 -> next cycle in_ready=1, out_valid=0, err_cnt=0; no result is emitted.
